// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch unit with a small prefetch queue
//
// Fetches sequential instruction words from a single-outstanding memory port
// and buffers {pc, instr} pairs for the decode stage. A redirect flushes the
// queue and restarts fetching at the word-aligned redirect address.
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   imem_re, imem_addr  one-cycle read request and its address
//   imem_valid, imem_rdata  read response strobe and data
//   id_ready            decode accepts the head entry this cycle
//   redirect, redirect_pc   flush and refetch from redirect_pc
//   instr_valid, instr, opcode, pc_out  queue head as seen by decode
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds fetch_count (enqueues) and
// flush_count (redirect cycles), 32-bit saturating counters.

module instr_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_re,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     flush_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];

  logic issue;
  logic enq;
  logic deq;
  logic unused_ok;

  // Requests are issued in the REQ cycle itself so that a one-cycle memory
  // yields an entry two cycles after the request. A redirect suppresses the
  // request so no stale fetch is ever left outstanding from REQ.
  assign issue = (state == REQ) && (count < FULL) && !redirect;
  assign enq   = (state == WAIT) && imem_valid && !redirect;
  assign deq   = instr_valid && id_ready && !redirect;

  assign imem_re   = issue;
  assign imem_addr = issue ? fetch_pc : '0;

  // Head outputs come only from queue storage; gating with instr_valid keeps
  // them at zero after reset and flush.
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? instr_q[head] : '0;
  assign pc_out      = instr_valid ? pc_q[head] : '0;
  assign opcode      = instr[6:0];

  assign unused_ok = ^redirect_pc[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_valid)    state <= REQ;
          else if (redirect) state <= DRAIN;  // response still in flight
        end
        DRAIN: begin
          if (imem_valid) state <= REQ;       // discard the stale response
        end
        default: state <= IDLE;
      endcase
      if (redirect) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      pc_q[tail]    <= req_pc;
      instr_q[tail] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (enq && (fetch_count != '1))      fetch_count <= fetch_count + 32'd1;
      if (redirect && (flush_count != '1)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue

module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_re;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  instr_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_re(imem_re), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc_out(pc_out)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 1;
  bit          busy = 0;
  int          cnt = 0;
  bit          drop = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] last_req_addr = '0;
  bit          popped = 0;
  int          push_total = 0;
  int          redir_total = 0;
  int          req_count = 0;
  bit          want_redirect = 0;
  bit          want_ready = 1;
  logic [31:0] want_rpc = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'h00A0_0033 ^ (a << 12) ^ {25'b0, a[8:2]};
  endfunction

  // One clock cycle: drive inputs at the falling edge, run the memory model,
  // then observe outputs and update the scoreboard.
  task automatic cycle();
    bit   do_push;
    int   pre_size;
    ent_t e;
    @(negedge clock);
    redirect    = want_redirect;
    redirect_pc = want_rpc;
    id_ready    = want_ready;
    imem_valid  = 1'b0;
    do_push     = 0;
    if (busy) begin
      if (cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = mem_data(req_addr);
        do_push    = !drop && !redirect;
        busy       = 0;
      end else begin
        cnt--;
        if (redirect) drop = 1;
      end
    end
    #1;
    popped   = 0;
    pre_size = sb.size();
    check("valid_vs_model", instr_valid, pre_size != 0);
    if (instr_valid && id_ready && !redirect && pre_size != 0) begin
      e = sb.pop_front();
      check("pc_out", pc_out, e.pc);
      check("instr", instr, e.ins);
      check("opcode", opcode, e.ins[6:0]);
      last_pop_pc = e.pc;
      popped = 1;
    end
    if (redirect) begin
      sb.delete();
      exp_addr = {want_rpc[31:2], 2'b00};
      redir_total++;
    end
    if (do_push) begin
      sb.push_back('{pc: req_addr, ins: mem_data(req_addr)});
      push_total++;
    end
    if (imem_re) begin
      check("imem_addr", imem_addr, exp_addr);
      check("req_not_full", pre_size < DEPTH, 1);
      check("one_outstanding", busy, 0);
      exp_addr      = exp_addr + 32'd4;
      busy          = 1;
      cnt           = lat;
      req_addr      = imem_addr;
      last_req_addr = imem_addr;
      drop          = 0;
      req_count++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    imem_valid = 1'b0;
    redirect = 1'b0;
    want_redirect = 0;
    sb.delete();
    busy = 0;
    drop = 0;
    exp_addr = '0;
    push_total = 0;
    redir_total = 0;
    req_count = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_first_pop(input int limit);
    for (int k = 0; k < limit; k++) begin
      cycle();
      if (popped) break;
    end
    check("pop_seen", popped, 1);
  endtask

  initial begin
    int first;
    int base;
    logic [31:0] a0;
    logic [31:0] a1;

    // Reset state
    want_ready = 1;
    lat = 1;
    repeat (2) @(negedge clock);
    #1;
    check("rst_imem_re", imem_re, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_pc_out", pc_out, 0);

    // Release with 1-cycle memory, decode always ready
    reset = 1'b0;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (i == 1) check("first_req", imem_re, 1);
      if (instr_valid && first < 0) begin
        first = i;
        check("first_pc", pc_out, 32'h0);
        check("first_opcode", opcode, 7'b0110011);
        check("first_instr", instr, 32'h00A0_0033);
      end
    end
    check("first_valid_cycle", first, 3);
    check("req_count_1cyc", req_count, 6);

    // Decode stalled: queue fills with exactly DEPTH requests
    do_reset();
    want_ready = 0;
    repeat (20) cycle();
    check("full_req_count", req_count, 4);
    check("full_valid", instr_valid, 1);
    check("full_head_pc", pc_out, 32'h0);
    check("full_no_req", imem_re, 0);

    // Redirect with a full queue
    want_redirect = 1;
    want_rpc = 32'h103;
    cycle();
    want_redirect = 0;
    cycle();
    check("valid_after_redirect", instr_valid, 0);
    check("redir_req", imem_re, 1);
    check("redir_addr", imem_addr, 32'h100);
    want_ready = 1;
    repeat (20) cycle();

    // Redirect in WAIT, response still two cycles away (DRAIN path)
    do_reset();
    lat = 3;
    for (int k = 0; k < 20 && !(busy && cnt >= 2); k++) cycle();
    check("wait_setup", busy && cnt >= 2, 1);
    want_redirect = 1;
    want_rpc = 32'h200;
    cycle();
    want_redirect = 0;
    wait_first_pop(40);
    check("drain_first_pc", last_pop_pc, 32'h200);

    // Redirect in WAIT in the same cycle as the response
    for (int k = 0; k < 20 && !(busy && cnt == 1); k++) cycle();
    check("wait_setup2", busy && cnt == 1, 1);
    want_redirect = 1;
    want_rpc = 32'h302;
    cycle();
    want_redirect = 0;
    wait_first_pop(40);
    check("same_cycle_first_pc", last_pop_pc, 32'h300);

    // fetch_pc wraps at the top of the address space
    lat = 1;
    want_redirect = 1;
    want_rpc = 32'hFFFF_FFFE;
    cycle();
    want_redirect = 0;
    base = req_count;
    a0 = '0;
    a1 = 32'hDEAD_BEEF;
    for (int k = 0; k < 30 && req_count < base + 2; k++) begin
      cycle();
      if (req_count == base + 1) a0 = last_req_addr;
      if (req_count == base + 2) a1 = last_req_addr;
    end
    check("wrap_addr0", a0, 32'hFFFF_FFFC);
    check("wrap_addr1", a1, 32'h0000_0000);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      want_ready = ($urandom_range(0, 3) != 0);
      want_redirect = ($urandom_range(0, 15) == 0);
      want_rpc = $urandom;
      if (!busy) lat = $urandom_range(1, 3);
      cycle();
    end
    want_redirect = 0;
    want_ready = 1;
    repeat (20) cycle();

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    lat = 1;
    want_ready = 1;
    for (int k = 0; k < 40 && push_total < 5; k++) cycle();
    want_redirect = 1;
    want_rpc = 32'h40;
    cycle();
    cycle();
    want_redirect = 0;
    cycle();
    check("fetch_count", fetch_count, 5);
    check("flush_count", flush_count, 2);
    check("model_redirects", redir_total, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
